// File: rtl/seq_modulus_pkg.sv
// +----------------------------------------------------------------------------+
// | seq_modulus_pkg : shared FSM states, default width, iteration-counter width |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package seq_modulus_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Wide enough to hold the iteration count WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_modulus_step.sv
// +----------------------------------------------------------------------------+
// | seq_modulus_step : one combinational restoring shift-subtract stage         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_modulus_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_dvd_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_quo_bit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // i_rem < i_dvs keeps w_shift < 2*i_dvs, so bit WIDTH of the difference is its sign.
    assign w_shift   = {i_rem, i_dvd_bit};
    assign w_diff    = w_shift - {1'b0, i_dvs};
    assign o_quo_bit = ~w_diff[WIDTH];
    assign o_rem     = o_quo_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/seq_modulus.sv
// +----------------------------------------------------------------------------+
// | seq_modulus : sequential divider, one quotient bit per cycle (x / y, x % y)  |
// | Rev 1.0 -- SEQ_MODULUS_SIGNED_EN adds port sgn for two's-complement mode     |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_modulus
    import seq_modulus_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SEQ_MODULUS_SIGNED_EN
    input  logic             sgn,
`endif
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rem,
    output logic [WIDTH-1:0] quo,
    output logic             dz
);

    localparam int               CNT_W       = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             dz_q, dz_d;

    logic             w_y_zero;
    logic             w_div_zero;
    logic [WIDTH-1:0] w_mag_x;
    logic [WIDTH-1:0] w_mag_y;
    logic [WIDTH-1:0] w_quo_fin;
    logic [WIDTH-1:0] w_rem_fin;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_step_bit;

    assign w_y_zero   = (y == '0);
    assign w_div_zero = (dvs_q == '0);

`ifdef SEQ_MODULUS_SIGNED_EN
    logic w_neg_x, w_neg_y;
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;

    assign w_neg_x   = sgn & x[WIDTH-1];
    assign w_neg_y   = sgn & y[WIDTH-1];
    assign w_mag_x   = w_neg_x ? -x : x;
    assign w_mag_y   = w_neg_y ? -y : y;
    // Most-negative / -1 yields magnitude 2^(WIDTH-1), which reads back as most-negative.
    assign w_quo_fin = neg_quo_q ? -dvd_q : dvd_q;
    assign w_rem_fin = neg_rem_q ? -prem_q : prem_q;

    always_comb begin
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (state_q == ST_IDLE && start) begin
            neg_quo_d = w_neg_x ^ w_neg_y;
            neg_rem_d = w_neg_x;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`else
    assign w_mag_x   = x;
    assign w_mag_y   = y;
    assign w_quo_fin = dvd_q;
    assign w_rem_fin = prem_q;
`endif

    seq_modulus_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_rem    (prem_q),
        .i_dvd_bit(dvd_q[WIDTH-1]),
        .i_dvs    (dvs_q),
        .o_rem    (w_step_rem),
        .o_quo_bit(w_step_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = w_y_zero ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt_q == C_LAST_ITER) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    // The dividend register shifts left and collects quotient bits at its LSB.
    always_comb begin
        cnt_d  = cnt_q;
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        prem_d = prem_q;
        done_d = 1'b0;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dz_d   = dz_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    dvd_d  = w_y_zero ? x : w_mag_x;
                    dvs_d  = w_mag_y;
                    prem_d = '0;
                end
            end
            ST_CALC: begin
                cnt_d  = cnt_q + C_CNT_ONE;
                dvd_d  = {dvd_q[WIDTH-2:0], w_step_bit};
                prem_d = w_step_rem;
            end
            ST_DONE: begin
                cnt_d  = '0;
                done_d = 1'b1;
                if (w_div_zero) begin
                    rem_d = dvd_q;
                    quo_d = '1;
                    dz_d  = 1'b1;
                end else begin
                    rem_d = w_rem_fin;
                    quo_d = w_quo_fin;
                    dz_d  = 1'b0;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            prem_q <= '0;
            done_q <= 1'b0;
            rem_q  <= '0;
            quo_q  <= '0;
            dz_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            prem_q <= prem_d;
            done_q <= done_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dz_q   <= dz_d;
        end
    end

    assign done = done_q;
    assign rem  = rem_q;
    assign quo  = quo_q;
    assign dz   = dz_q;

endmodule

`default_nettype wire

// File: doc/seq_modulus.md
SEQ_MODULUS -- requirements
Module: seq_modulus

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; legal range 4..32.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port start  input  1  request; sampled only in IDLE.
REQ-005 Port x  input  WIDTH  dividend; captured on accepted start.
REQ-006 Port y  input  WIDTH  divisor; captured on accepted start.
REQ-007 Port busy  output  1  high while an operation is in progress.
REQ-008 Port done  output  1  one-cycle pulse marking result valid.
REQ-009 Port rem  output  WIDTH  remainder x mod y.
REQ-010 Port quo  output  WIDTH  quotient x / y.
REQ-011 Port dz  output  1  divide-by-zero flag for the current result.

Function
REQ-012 FSM states IDLE, CALC, DONE; IDLE->CALC on start with y!=0; IDLE->DONE on start with y==0; CALC->DONE after WIDTH iterations; DONE->IDLE unconditionally.
REQ-013 CALC performs one restoring shift-subtract iteration per cycle on registered operands; a log2(WIDTH)+1-bit counter counts iterations.
REQ-014 Start accepted at edge N: busy high from edge N through edge N+WIDTH+1; done high for exactly the cycle following edge N+WIDTH+1.
REQ-015 y==0: done high for the cycle following edge N+1; rem = x, quo = all ones, dz = 1.
REQ-016 y!=0: dz = 0; results exact integer division, no rounding.
REQ-017 x<y: quo = 0, rem = x; x==0: quo = 0, rem = 0.
REQ-018 start while busy ignored; inputs x, y may change freely after acceptance without effect.
REQ-019 start high in DONE cycle ignored; a new start is accepted only in IDLE (back-to-back throughput one result per WIDTH+2 cycles).
REQ-020 rem, quo, dz hold last result until the next done; they update only at the edge that raises done.

Reset
REQ-021 rst_n low forces IDLE, busy=0, done=0, rem=0, quo=0, dz=0, counter=0, regardless of clock.
REQ-022 Reset mid-CALC aborts the operation; no done pulse is produced for it.
REQ-023 First start is accepted at the first rising edge with rst_n high.

Configuration
REQ-024 Macro SEQ_MODULUS_SIGNED_EN, when defined, adds input port sgn (1 bit, sampled with start) selecting two's-complement operation.
REQ-025 Signed mode: quotient truncates toward zero, remainder takes dividend's sign (|rem|<|y|); operands magnitude-converted before CALC, signs fixed up in DONE, latency unchanged.
REQ-026 Signed overflow (x = most negative, y = -1): quo = most negative, rem = 0, dz = 0.
REQ-027 Signed y==0: rem = x, quo = all ones, dz = 1.
REQ-028 Macro undefined: no sgn port, unsigned-only operation, no sign logic synthesised.

Structure
REQ-029 Shared package seq_modulus_pkg holds the state enumeration (IDLE, CALC, DONE), default WIDTH constant and counter-width function.
REQ-030 One sub-module, seq_modulus_step: combinational single shift-subtract stage (partial remainder, dividend bit, divisor in; next partial remainder, quotient bit out), instantiated once.

Verification (WIDTH=16)
REQ-031 x=100, y=7, start at edge N -> done at cycle after edge N+17, quo=14, rem=2, dz=0; busy high 17 cycles.
REQ-032 x=1234, y=0 -> done at cycle after edge N+1, rem=1234, quo=0xFFFF, dz=1.
REQ-033 x=5, y=9, then x=0xFFFF, y=1 back-to-back starts -> quo=0/rem=5, then quo=0xFFFF/rem=0; second start pulsed during busy and DONE ignored.
REQ-034 x=50000, y=3, rst_n low at edge N+8 for 2 cycles -> outputs zero, no done; next start x=50000, y=3 -> quo=16666, rem=2.
REQ-035 SEQ_MODULUS_SIGNED_EN, sgn=1: x=-7, y=2 -> quo=-3, rem=-1; x=0x8000, y=0xFFFF -> quo=0x8000, rem=0, dz=0.
